btn_conditioner: RTL

Per-button input conditioner sitting between the raw board push-buttons and GamePlay. Each button is synchronised to Clk100M, debounced with a cycle counter, and converted into a clean stable level plus a one-cycle press pulse (`blip`) that GamePlay consumes as `userUp`/`userDown`. It replaces the separate slow-clock sampling and edge-pulse stages with one block running entirely in the Clk100M domain.

---
 rtl/btn_conditioner.sv | 98 +++++++++
 1 files changed

// File: rtl/btn_conditioner.sv
// btn_conditioner: per-button synchroniser, debouncer and press-pulse generator in the Clk100M domain.
// Optional auto-repeat of the press pulse is compiled in when BTN_AUTOREPEAT_EN is defined.
module btn_conditioner #(
    parameter int NBTN            = 3,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic            Clk100M,
    input  logic            reset,
    input  logic [NBTN-1:0] btnIn,
    output logic [NBTN-1:0] level,
    output logic [NBTN-1:0] blip
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
`ifdef BTN_AUTOREPEAT_EN
    typedef enum logic [1:0] {RELEASED, HELD, REPEATING} state_t;
`else
    typedef enum logic [1:0] {RELEASED, HELD} state_t;
`endif
    genvar g;
    for (g = 0; g < NBTN; g++) begin : g_ch
        logic          s1_q, s2_q, level_q, blip_q;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          hit, rise, fall;
        state_t        state_q;
`ifdef BTN_AUTOREPEAT_EN
        logic [31:0]   rpt_q, rpt_d;
        logic          rpt_hit;
`endif
        // two-flop synchroniser for the raw pin
        always_ff @(posedge Clk100M or posedge reset) begin
            if (reset) begin
                s1_q <= 1'b0;
                s2_q <= 1'b0;
            end else begin
                s1_q <= btnIn[g];
                s2_q <= s1_q;
            end
        end
        // count consecutive disagreeing cycles; the last one flips the level
        always_comb begin
            hit   = (s2_q != level_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
            cnt_d = (s2_q == level_q || hit) ? '0 : cnt_q + 1'b1;
            rise  = hit && !level_q;
            fall  = hit && level_q;
`ifdef BTN_AUTOREPEAT_EN
            rpt_hit = (state_q == HELD) ? (rpt_q == 32'(REPEAT_DELAY - 1)) : (rpt_q == 32'(REPEAT_PERIOD - 1));
            rpt_d   = (state_q == RELEASED || fall || rpt_hit) ? 32'd0 : rpt_q + 32'd1;
`endif
        end
        // debounce counter and accepted level
        always_ff @(posedge Clk100M or posedge reset) begin
            if (reset) begin
                cnt_q   <= '0;
                level_q <= 1'b0;
            end else begin
                cnt_q   <= cnt_d;
                level_q <= level_q ^ hit;
            end
        end
        // press state machine; release beats a coincident repeat expiry
        always_ff @(posedge Clk100M or posedge reset) begin
            if (reset) begin
                state_q <= RELEASED;
                blip_q  <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
                rpt_q   <= 32'd0;
`endif
            end else begin
                blip_q <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
                rpt_q  <= rpt_d;
`endif
                case (state_q)
                    RELEASED: if (rise) begin
                        state_q <= HELD;
                        blip_q  <= 1'b1;
                    end
`ifdef BTN_AUTOREPEAT_EN
                    HELD: if (fall) state_q <= RELEASED;
                    else if (rpt_hit) begin
                        state_q <= REPEATING;
                        blip_q  <= 1'b1;
                    end
                    REPEATING: if (fall) state_q <= RELEASED;
                    else if (rpt_hit) blip_q <= 1'b1;
`else
                    HELD: if (fall) state_q <= RELEASED;
`endif
                    default: state_q <= RELEASED;
                endcase
            end
        end
        assign level[g] = level_q;
        assign blip[g]  = blip_q;
    end
endmodule
